// File: rtl/chatter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : chatter_pkg                                            |
// | Description : Shared types and constants for the contact-bounce      |
// |               generator (state encoding, LFSR polynomial and seed).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package chatter_pkg;

    localparam int              c_lfsr_w    = 16;
    localparam logic [15:0]     c_lfsr_mask = 16'hB400;
    localparam logic [15:0]     c_lfsr_seed = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [c_lfsr_w-1:0] lfsr_next(input logic [c_lfsr_w-1:0] s);
        return s[0] ? ((s >> 1) ^ c_lfsr_mask) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chatter_gen_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lfsr16                                                 |
// | Description : Free-running 16-bit Galois LFSR with a fixed seed.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lfsr16
    import chatter_pkg::*;
#(
    parameter logic [15:0] SEED = c_lfsr_seed
) (
    input  logic                i_sys_clk,
    input  logic                i_rst_n,
    output logic [c_lfsr_w-1:0] o_state
);

    // An all-zero seed would lock the register up, so fall back to the default.
    localparam logic [c_lfsr_w-1:0] c_seed_eff = (SEED == 16'h0000) ? c_lfsr_seed : SEED;

    logic [c_lfsr_w-1:0] r_state;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_state <= c_seed_eff;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/chatter_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : chatter_gen                                            |
// | Description : Emulates mechanical contact bounce on a clean level by |
// |               emitting an odd burst of LFSR-timed toggles + settle.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module chatter_gen
    import chatter_pkg::*;
#(
    parameter int          BOUNCE_MAX = 7,
    parameter int          HOLD_BITS  = 8,
    parameter int          SETTLE_CYC = 1000,
    parameter logic [15:0] LFSR_SEED  = c_lfsr_seed
) (
    input  logic i_sys_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_level,
    output logic o_signal,
    output logic o_busy,
    output logic o_done
);

    localparam int                   c_settle_w    = $clog2(SETTLE_CYC + 1);
    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYC - 1);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);
    localparam logic [HOLD_BITS-1:0]  c_hold_one    = HOLD_BITS'(1);
    localparam logic [3:0]            c_bmax        = 4'(BOUNCE_MAX);

    logic [c_lfsr_w-1:0]   w_lfsr;
    logic                  w_unused;
    logic [3:0]            w_n;
    logic [HOLD_BITS-1:0]  w_hold_raw;
    logic [HOLD_BITS-1:0]  w_hold_load;

    state_t                r_state;
    logic                  r_signal;
    logic                  r_busy;
    logic                  r_done;
    logic [HOLD_BITS-1:0]  r_hold;
    logic [4:0]            r_left;
    logic [c_settle_w-1:0] r_settle;

    lfsr16 #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .i_sys_clk (i_sys_clk),
        .i_rst_n   (i_rst_n),
        .o_state   (w_lfsr)
    );

    // Only a few LFSR bits feed the timing; fold the rest so the bus is fully consumed.
    assign w_unused = ^w_lfsr;

    assign w_n         = (w_lfsr[3:0] > c_bmax) ? c_bmax : w_lfsr[3:0];
    assign w_hold_raw  = w_lfsr[HOLD_BITS-1:0];
    // Counter holds plateau length minus one; a zero sample means a 1-cycle plateau.
    assign w_hold_load = (w_hold_raw == '0) ? '0 : (w_hold_raw - c_hold_one);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_signal <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hold   <= '0;
            r_left   <= '0;
            r_settle <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_en) begin
                        r_signal <= i_level;
                    end else if (i_level != r_signal) begin
                        r_signal <= ~r_signal;
                        r_busy   <= 1'b1;
                        if (w_n == 4'd0) begin
                            r_state  <= S_SETTLE;
                            r_settle <= c_settle_load;
                            r_hold   <= '0;
                            r_left   <= '0;
                        end else begin
                            r_state  <= S_BOUNCE;
                            r_hold   <= w_hold_load;
                            r_left   <= {w_n, 1'b0};
                        end
                    end
                end

                S_BOUNCE: begin
                    if (!i_en) begin
                        r_state  <= S_IDLE;
                        r_signal <= i_level;
                        r_busy   <= 1'b0;
                        r_hold   <= '0;
                        r_left   <= '0;
                        r_settle <= '0;
                    end else if (r_hold != '0) begin
                        r_hold <= r_hold - c_hold_one;
                    end else begin
                        r_signal <= ~r_signal;
                        r_left   <= r_left - 5'd1;
                        if (r_left == 5'd1) begin
                            r_state  <= S_SETTLE;
                            r_settle <= c_settle_load;
                            r_hold   <= '0;
                        end else begin
                            r_hold <= w_hold_load;
                        end
                    end
                end

                S_SETTLE: begin
                    if (!i_en) begin
                        r_state  <= S_IDLE;
                        r_signal <= i_level;
                        r_busy   <= 1'b0;
                        r_hold   <= '0;
                        r_left   <= '0;
                        r_settle <= '0;
                    end else if (r_settle != '0) begin
                        r_settle <= r_settle - c_settle_one;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_signal = r_signal;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chatter_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_chatter_gen                                         |
// | Description : Self-checking bench: directed scenarios plus random    |
// |               stimulus against an event-schedule reference model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_chatter_gen;

    localparam int          C_BMAX   = 3;
    localparam int          C_HB     = 3;
    localparam int          C_SETTLE = 5;
    localparam logic [15:0] C_SEED   = 16'h1D2B;

    logic clk;
    logic rst_n, c_rst_n;
    logic a_en, a_level, a_sig, a_busy, a_done;
    logic b_en, b_level, b_sig, b_busy, b_done;
    logic c_en, c_level, c_sig, c_busy, c_done;

    int n_cmp = 0;
    int n_bad = 0;

    chatter_gen dut_a (
        .i_sys_clk (clk), .i_rst_n (rst_n), .i_en (a_en), .i_level (a_level),
        .o_signal (a_sig), .o_busy (a_busy), .o_done (a_done)
    );

    chatter_gen #(.BOUNCE_MAX(0), .SETTLE_CYC(4)) dut_b (
        .i_sys_clk (clk), .i_rst_n (rst_n), .i_en (b_en), .i_level (b_level),
        .o_signal (b_sig), .o_busy (b_busy), .o_done (b_done)
    );

    chatter_gen #(.BOUNCE_MAX(C_BMAX), .HOLD_BITS(C_HB), .SETTLE_CYC(C_SETTLE),
                  .LFSR_SEED(C_SEED)) dut_c (
        .i_sys_clk (clk), .i_rst_n (c_rst_n), .i_en (c_en), .i_level (c_level),
        .o_signal (c_sig), .o_busy (c_busy), .o_done (c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; a_en = 1'b1; a_level = 1'b1; b_en = 1'b1; b_level = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_sig, a_busy, a_done} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: sig/busy/done got %b want 000", k, {a_sig, a_busy, a_done});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_sig, a_busy, a_done} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_release_start: sig/busy/done got %b want 110", {a_sig, a_busy, a_done});
        end
        n_cmp++;
        if ({b_sig, b_busy, b_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release_idle: sig/busy/done got %b want 000", {b_sig, b_busy, b_done});
        end
    endtask

    task automatic test_abort();
        int dones, wrong;
        a_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_sig, a_busy, a_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL abort_next: sig/busy/done got %b want 100", {a_sig, a_busy, a_done});
        end
        @(negedge clk);
        a_en = 1'b1;
        dones = 0; wrong = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (a_done) dones++;
            if (a_busy !== 1'b0 || a_sig !== 1'b1) wrong++;
        end
        n_cmp++;
        if (dones != 0 || wrong != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: done pulses %0d, busy/level deviations %0d, want 0/0", dones, wrong);
        end
    endtask

    task automatic test_defaults();
        int edges, run, bad_plat, bad_busy, settle, extra;
        bit prev, finished;
        a_en = 1'b0; a_level = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (a_sig !== 1'b0) begin
            n_bad++;
            $display("FAIL defaults_prep: sig got %b want 0", a_sig);
        end
        a_en = 1'b1;
        @(negedge clk);
        a_level = 1'b1;
        prev = 1'b0; edges = 0; run = 0; bad_plat = 0; bad_busy = 0; settle = -1; finished = 1'b0;
        for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
            @(negedge clk);
            if (a_sig !== prev) begin
                if (edges > 0 && (run < 1 || run > 255)) bad_plat++;
                edges++;
                run = 1;
                prev = a_sig;
            end else begin
                run++;
            end
            if (a_done === 1'b1) begin
                settle = run - 1;
                finished = 1'b1;
            end else if (a_busy !== 1'b1) begin
                bad_busy++;
            end
        end
        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL defaults_timeout: no done within 8000 cycles, edges so far %0d", edges);
        end
        n_cmp++;
        if (edges % 2 != 1 || edges > 15) begin
            n_bad++;
            $display("FAIL defaults_edges: got %0d edges, want odd and <=15", edges);
        end
        n_cmp++;
        if (bad_plat != 0 || bad_busy != 0) begin
            n_bad++;
            $display("FAIL defaults_plateau: bad plateaus %0d, busy drops %0d, want 0/0", bad_plat, bad_busy);
        end
        n_cmp++;
        if (settle != 1000 || a_sig !== 1'b1) begin
            n_bad++;
            $display("FAIL defaults_settle: settle %0d level %b, want 1000 and 1", settle, a_sig);
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_sig !== 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL defaults_after: %0d cycles with done/busy/level off, want 0", extra);
        end
    endtask

    task automatic test_passthrough();
        bit pat[4];
        bit last;
        pat = '{1'b0, 1'b1, 1'b1, 1'b0};
        a_en = 1'b0;
        last = a_sig;
        for (int k = 0; k < 4; k++) begin
            a_level = pat[k];
            #1;
            n_cmp++;
            if (a_sig !== last) begin
                n_bad++;
                $display("FAIL pass_latency step %0d: sig got %b before edge, want %b", k, a_sig, last);
            end
            @(negedge clk);
            n_cmp++;
            if (a_sig !== pat[k] || a_busy !== 1'b0 || a_done !== 1'b0) begin
                n_bad++;
                $display("FAIL pass_step %0d: sig/busy/done got %b%b%b want %b00", k, a_sig, a_busy, a_done, pat[k]);
            end
            last = pat[k];
        end
    endtask

    task automatic test_settle_min();
        int edges;
        bit prev, es, eb, ed;
        b_en = 1'b1; b_level = 1'b0;
        @(negedge clk);
        b_level = 1'b1;
        prev = b_sig; edges = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            es = 1'b1; eb = (k <= 4); ed = (k == 5);
            if (b_sig !== prev) edges++;
            prev = b_sig;
            n_cmp++;
            if ({b_sig, b_busy, b_done} !== {es, eb, ed}) begin
                n_bad++;
                $display("FAIL settle_min cyc %0d: sig/busy/done got %b want %b", k, {b_sig, b_busy, b_done}, {es, eb, ed});
            end
        end
        n_cmp++;
        if (edges != 1) begin
            n_bad++;
            $display("FAIL settle_min_edges: got %0d edges want 1", edges);
        end
    endtask

    task automatic test_settle_ignore();
        bit es, eb, ed;
        b_en = 1'b0; b_level = 1'b0;
        @(negedge clk);
        b_en = 1'b1;
        @(negedge clk);
        b_level = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) b_level = 1'b0;
            es = (k <= 5);
            eb = (k <= 4) || (k >= 6 && k <= 9);
            ed = (k == 5) || (k == 10);
            n_cmp++;
            if ({b_sig, b_busy, b_done} !== {es, eb, ed}) begin
                n_bad++;
                $display("FAIL settle_ignore cyc %0d: sig/busy/done got %b want %b", k, {b_sig, b_busy, b_done}, {es, eb, ed});
            end
        end
    endtask

    // Reference: at each start the full toggle schedule is precomputed from LFSR values.
    task automatic test_random();
        int unsigned q[$];
        bit ms, mb, md, en, lv, rn;
        logic [15:0] ml, l;
        int unsigned t, done_t, tt, n, h;
        int bad_here;
        ms = 1'b0; mb = 1'b0; md = 1'b0; ml = C_SEED; t = 0; done_t = 0;
        en = 1'b1; lv = 1'b0; bad_here = 0;
        @(negedge clk);
        c_rst_n = 1'b0; c_en = 1'b1; c_level = 1'b0;
        t = t + 1;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({c_sig, c_busy, c_done} !== {ms, mb, md}) begin
                n_bad++;
                bad_here++;
                if (bad_here <= 10)
                    $display("FAIL random cyc %0d: sig/busy/done got %b want %b", k, {c_sig, c_busy, c_done}, {ms, mb, md});
            end
            rn = (k == 0) ? 1'b1 : ($urandom_range(0, 399) != 0);
            if (en) en = ($urandom_range(0, 59) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) lv = ~lv;
            c_rst_n = rn; c_en = en; c_level = lv;
            if (!rn) begin
                ms = 1'b0; mb = 1'b0; md = 1'b0; q.delete(); ml = C_SEED;
            end else begin
                md = 1'b0;
                if (mb) begin
                    if (!en) begin
                        ms = lv; mb = 1'b0; q.delete();
                    end else if (q.size() != 0) begin
                        if (t == q[0]) begin
                            ms = ~ms;
                            void'(q.pop_front());
                        end
                    end else if (t == done_t) begin
                        mb = 1'b0; md = 1'b1;
                    end
                end else if (!en) begin
                    ms = lv;
                end else if (lv != ms) begin
                    ms = ~ms; mb = 1'b1;
                    n = (int'(ml[3:0]) > C_BMAX) ? C_BMAX : int'(ml[3:0]);
                    l = ml; tt = t;
                    for (int i = 0; i < 2 * n; i++) begin
                        h = int'(l) % (1 << C_HB);
                        if (h == 0) h = 1;
                        for (int j = 0; j < h; j++) l = step(l);
                        tt = tt + h;
                        q.push_back(tt);
                    end
                    done_t = tt + C_SETTLE;
                end
                ml = step(ml);
            end
            t = t + 1;
        end
    endtask

    initial begin
        rst_n = 1'b0; c_rst_n = 1'b0;
        a_en = 1'b0; a_level = 1'b0;
        b_en = 1'b0; b_level = 1'b0;
        c_en = 1'b0; c_level = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_abort();
        test_defaults();
        test_passthrough();
        test_settle_min();
        test_settle_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chatter_gen.md
CHATTER_GEN -- requirements
Module: chatter_gen

Interface
REQ-001 SHALL have parameter BOUNCE_MAX, default 7, max extra bounce pairs per transition (0..15).
REQ-002 SHALL have parameter HOLD_BITS, default 8, width of the per-plateau hold value taken from the LFSR (1..15).
REQ-003 SHALL have parameter SETTLE_CYC, default 1000, stable cycles after the last toggle before completion (>=1).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-005 i_sys_clk  input  1  sole clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_en  input  1  1 = emulate bounce; 0 = clean pass-through.
REQ-008 i_level  input  1  clean target level, synchronous to i_sys_clk.
REQ-009 o_signal  output  1  registered bouncy output; drives a chatter_button input in loopback tests.
REQ-010 o_busy  output  1  high while a bounce or settle sequence is in progress.
REQ-011 o_done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-012 SHALL run a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advancing every cycle; it never reaches zero.
REQ-013 SHALL implement states IDLE, BOUNCE, SETTLE.
REQ-014 IDLE with i_en=0: o_signal <= i_level every cycle (1-cycle latency); o_busy=0, o_done=0.
REQ-015 IDLE with i_en=1 and i_level!=o_signal: next cycle o_signal toggles (first toggle), o_busy=1, state -> BOUNCE or SETTLE per REQ-018.
REQ-016 At the start, n = min(lfsr[3:0], BOUNCE_MAX) SHALL be latched; total toggles T = 2n+1, so the final level equals the target.
REQ-017 Each plateau (including the one after the first toggle) SHALL last h cycles, h = lfsr[HOLD_BITS-1:0] sampled at the toggle, forced to 1 if zero; i.e. 1 <= h <= 2^HOLD_BITS-1.
REQ-018 After the T-th toggle, state SHALL be SETTLE with o_signal held; with n=0, the first toggle enters SETTLE directly.
REQ-019 SETTLE SHALL hold o_signal for SETTLE_CYC cycles counted from the first cycle the last toggle is visible; the next cycle is IDLE with o_done=1, o_busy=0.
REQ-020 Changes on i_level during BOUNCE/SETTLE SHALL be ignored; IDLE re-evaluates REQ-014/015 starting the cycle after o_done (no done/start overlap).
REQ-021 i_en=0 during BOUNCE/SETTLE SHALL abort: next cycle o_signal=i_level, state IDLE, o_busy=0, no o_done.
REQ-022 Hold and settle counters SHALL saturate-free count down to zero; no wrap-around or extra toggle on expiry.

Reset
REQ-023 i_rst_n=0 at a clock edge SHALL force state IDLE, o_signal=0, o_busy=0, o_done=0, counters=0, LFSR=LFSR_SEED, overriding all other inputs, including mid-sequence.
REQ-024 First cycle after release SHALL behave as IDLE per REQ-014/015.

Structure
REQ-025 Shared package chatter_pkg SHALL hold state encodings (IDLE/BOUNCE/SETTLE), LFSR width 16, mask 16'hB400, default seed.
REQ-026 LFSR SHALL be a sub-module lfsr16 (clock, sync active-low reset, seed parameter, 16-bit state output); the FSM and counters stay in chatter_gen.

Verification
REQ-027 Reset: i_rst_n=0 for 3 cycles, i_level=1, i_en=1 -> o_signal=0, o_busy=0, o_done=0 throughout.
REQ-028 BOUNCE_MAX=0, SETTLE_CYC=4: i_level 0->1 at cycle 0 -> o_signal=1 at cycle 1, o_busy=1 cycles 1-4, cycle 5 o_done=1 and o_busy=0, exactly one edge.
REQ-029 Defaults, 0->1 transition -> odd edge count <=15, each plateau 1..255 cycles, final o_signal=1 for >=1000 cycles, one o_done.
REQ-030 Abort: i_en 1->0 mid-BOUNCE with i_level=1 -> next cycle o_signal=1, o_busy=0; no o_done ever for that sequence.
REQ-031 i_level 1->0 during SETTLE -> ignored until o_done; next cycle a new sequence toggles o_signal toward 0.
REQ-032 i_en=0, i_level pattern 0,1,1,0 -> o_signal the same pattern delayed 1 cycle; o_busy stays 0.
